// File: rtl/id_ex_if.sv
// id_ex_if: fetch, writeback and EX-side signals of the decode/operand-fetch stage
interface id_ex_if #(parameter int DW = 32, parameter int AW = 5);
    logic [31:0]   Instr;
    logic          in_valid;
    logic          in_ready;
    logic          WE;
    logic [AW-1:0] WA;
    logic [DW-1:0] WD;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] OP1;
    logic [DW-1:0] OP2;
    logic [2:0]    ALUCtl;
    logic [AW-1:0] Wdest;
    logic          RegWrite;
    logic          Illegal;
    modport master (
        output Instr, in_valid, WE, WA, WD, flush, out_ready,
        input  in_ready, out_valid, OP1, OP2, ALUCtl, Wdest, RegWrite, Illegal
    );
    modport slave (
        input  Instr, in_valid, WE, WA, WD, flush, out_ready,
        output in_ready, out_valid, OP1, OP2, ALUCtl, Wdest, RegWrite, Illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: register file, instruction decode and one-entry operand register feeding the ALU
module id_ex_stage #(
    parameter int         DW      = 32,
    parameter int         AW      = 5,
    parameter logic [2:0] NOP_CTL = 3'b011
) (
    input logic   clk,
    input logic   rst,
    id_ex_if.slave bus
);
    logic [DW-1:0] rf_q [2**AW];
    logic [5:0]    opc, funct;
    logic [AW-1:0] rs, rt, rd;
    logic [15:0]   imm;
    logic          wr_en, capture;
    logic [DW-1:0] rs_val, rt_val;
    logic [2:0]    dec_ctl;
    logic [DW-1:0] dec_op2;
    logic [AW-1:0] dec_wdest;
    logic          dec_rw, dec_ill, dec_rtreg;
    logic          valid_q, valid_d, rw_q, rw_d, ill_q, ill_d, rtreg_q, rtreg_d;
    logic [DW-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [2:0]    ctl_q, ctl_d;
    logic [AW-1:0] wdest_q, wdest_d, rs_q, rs_d, rt_q, rt_d;

    assign opc   = bus.Instr[31:26];
    assign rs    = bus.Instr[25:21];
    assign rt    = bus.Instr[20:16];
    assign rd    = bus.Instr[15:11];
    assign imm   = bus.Instr[15:0];
    assign funct = bus.Instr[5:0];
    assign wr_en = bus.WE && bus.WA != '0;
    // same-cycle writeback is forwarded so the captured operand is never one write behind
    assign rs_val = (wr_en && bus.WA == rs) ? bus.WD : rf_q[rs];
    assign rt_val = (wr_en && bus.WA == rt) ? bus.WD : rf_q[rt];
    assign bus.in_ready = !valid_q || bus.out_ready;
    assign capture = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        dec_ctl   = NOP_CTL;
        dec_op2   = rt_val;
        dec_wdest = rd;
        dec_rw    = 1'b1;
        dec_ill   = 1'b0;
        dec_rtreg = 1'b1;
        if (opc == 6'b000000) begin
            case (funct)
                6'b100100: dec_ctl = 3'b000;
                6'b100101: dec_ctl = 3'b001;
                6'b100000: dec_ctl = 3'b010;
                6'b100010: dec_ctl = 3'b110;
                6'b101010: dec_ctl = 3'b111;
                6'b000000: dec_rw  = 1'b0;
                default: begin
                    dec_rw  = 1'b0;
                    dec_ill = 1'b1;
                end
            endcase
        end else begin
            dec_wdest = rt;
            dec_rtreg = 1'b0;
            case (opc)
                6'b001000: begin
                    dec_ctl = 3'b010;
                    dec_op2 = {{(DW-16){imm[15]}}, imm};
                end
                6'b001010: begin
                    dec_ctl = 3'b111;
                    dec_op2 = {{(DW-16){imm[15]}}, imm};
                end
                6'b001100: begin
                    dec_ctl = 3'b000;
                    dec_op2 = {{(DW-16){1'b0}}, imm};
                end
                6'b001101: begin
                    dec_ctl = 3'b001;
                    dec_op2 = {{(DW-16){1'b0}}, imm};
                end
                default: begin
                    dec_rw  = 1'b0;
                    dec_ill = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        valid_d = capture || (valid_q && !bus.out_ready && !bus.flush);
        op1_d   = op1_q;
        op2_d   = op2_q;
        ctl_d   = ctl_q;
        wdest_d = wdest_q;
        rw_d    = rw_q;
        ill_d   = ill_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rtreg_d = rtreg_q;
        if (capture) begin
            op1_d   = rs_val;
            op2_d   = dec_op2;
            ctl_d   = dec_ctl;
            wdest_d = dec_wdest;
            rw_d    = dec_rw;
            ill_d   = dec_ill;
            rs_d    = rs;
            rt_d    = rt;
            rtreg_d = dec_rtreg;
        end else if (valid_q && !bus.out_ready && wr_en) begin
            // stalled entry tracks writebacks to its source registers
            if (bus.WA == rs_q) op1_d = bus.WD;
            if (rtreg_q && bus.WA == rt_q) op2_d = bus.WD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            ctl_q   <= NOP_CTL;
            wdest_q <= '0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            rtreg_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            ctl_q   <= ctl_d;
            wdest_q <= wdest_d;
            rw_q    <= rw_d;
            ill_q   <= ill_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rtreg_q <= rtreg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[bus.WA] <= bus.WD;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.OP1       = op1_q;
    assign bus.OP2       = op2_q;
    assign bus.ALUCtl    = ctl_q;
    assign bus.Wdest     = wdest_q;
    assign bus.RegWrite  = rw_q;
    assign bus.Illegal   = ill_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus random stimulus, scoreboard checked against an instruction-level model
module tb_id_ex_stage;
    typedef struct {
        logic [31:0] op1, op2;
        logic [2:0]  ctl;
        logic [4:0]  wdest, rs, rt;
        logic        rw, ill, rtreg, chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rf [32];
    exp_t        q[$];
    exp_t        m_e;
    int          compared = 0;
    int          mismatched = 0;

    id_ex_if bus();
    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t decode(input logic [31:0] i);
        exp_t e;
        logic [15:0] imm = i[15:0];
        e.rs = i[25:21]; e.rt = i[20:16];
        e.op1 = rf[e.rs]; e.op2 = rf[e.rt];
        e.ctl = 3'b011; e.rw = 1'b1; e.ill = 1'b0; e.chk = 1'b1;
        if (i[31:26] == 6'h00) begin
            e.rtreg = 1'b1; e.wdest = i[15:11];
            case (i[5:0])
                6'h24: e.ctl = 3'b000;
                6'h25: e.ctl = 3'b001;
                6'h20: e.ctl = 3'b010;
                6'h22: e.ctl = 3'b110;
                6'h2A: e.ctl = 3'b111;
                6'h00: begin e.rw = 1'b0; e.chk = 1'b0; end
                default: e.ill = 1'b1;
            endcase
        end else begin
            e.rtreg = 1'b0; e.wdest = e.rt;
            case (i[31:26])
                6'h08: begin e.ctl = 3'b010; e.op2 = 32'($signed(imm)); end
                6'h0A: begin e.ctl = 3'b111; e.op2 = 32'($signed(imm)); end
                6'h0C: begin e.ctl = 3'b000; e.op2 = {16'h0, imm}; end
                6'h0D: begin e.ctl = 3'b001; e.op2 = {16'h0, imm}; end
                default: e.ill = 1'b1;
            endcase
        end
        if (e.ill) begin e.ctl = 3'b011; e.rw = 1'b0; e.chk = 1'b0; end
        return e;
    endfunction

    // architectural effect of one clock edge, given the inputs presented during that cycle
    task automatic model_edge();
        bit cap;
        if (rst) begin
            foreach (rf[k]) rf[k] = '0;
            q.delete();
            return;
        end
        cap = bus.in_valid && (q.size() == 0 || bus.out_ready) && !bus.flush;
        if (bus.WE && bus.WA != 0) rf[bus.WA] = bus.WD;
        if (bus.flush) q.delete();
        else if (cap) q.push_back(decode(bus.Instr));
        else if (q.size() != 0 && !bus.out_ready && bus.WE && bus.WA != 0) begin
            if (bus.WA == q[0].rs) q[0].op1 = bus.WD;
            if (q[0].rtreg && bus.WA == q[0].rt) q[0].op2 = bus.WD;
        end
    endtask

    task automatic cycle(input logic [31:0] ins, input logic iv, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic fl, input logic ordy, input logic r);
        bus.Instr = ins; bus.in_valid = iv; bus.WE = we; bus.WA = wa; bus.WD = wd;
        bus.flush = fl; bus.out_ready = ordy; rst = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
        chk({tag, "_op1"}, bus.OP1, 32'h0);
        chk({tag, "_op2"}, bus.OP2, 32'h0);
        chk({tag, "_ctl"}, 32'(bus.ALUCtl), 32'h3);
        chk({tag, "_wdest"}, 32'(bus.Wdest), 32'h0);
        chk({tag, "_rw"}, 32'(bus.RegWrite), 32'h0);
        chk({tag, "_ill"}, 32'(bus.Illegal), 32'h0);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0] fn [6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h00};
        logic [5:0] io [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
        logic [5:0] bad [4] = '{6'h02, 6'h23, 6'h3F, 6'h0F};
        logic [4:0] a = 5'($urandom_range(0, 7));
        logic [4:0] b = 5'($urandom_range(0, 7));
        logic [4:0] c = 5'($urandom_range(0, 7));
        int k = $urandom_range(0, 10);
        if (k < 6) return {6'h00, a, b, c, 5'h00, fn[k]};
        if (k < 10) return {io[k-6], a, b, 16'($urandom)};
        if ($urandom_range(0, 1) == 1) return {bad[$urandom_range(0, 3)], a, b, 16'($urandom)};
        return {6'h00, a, b, c, 5'h00, 6'h21};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() == 0 || bus.out_ready));
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
                if (q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_output: got op1 %h expected no entry", bus.OP1);
                end else begin
                    m_e = q.pop_front();
                    chk("ALUCtl", 32'(bus.ALUCtl), 32'(m_e.ctl));
                    chk("RegWrite", 32'(bus.RegWrite), 32'(m_e.rw));
                    chk("Illegal", 32'(bus.Illegal), 32'(m_e.ill));
                    if (!m_e.ill) chk("Wdest", 32'(bus.Wdest), 32'(m_e.wdest));
                    if (m_e.chk) begin
                        chk("OP1", bus.OP1, m_e.op1);
                        chk("OP2", bus.OP2, m_e.op2);
                    end
                end
            end
        end
    end

    initial begin
        foreach (rf[k]) rf[k] = '0;
        cycle(32'h0, 0, 0, 0, 0, 0, 1, 1);
        cycle(32'h0, 0, 0, 0, 0, 0, 1, 1);
        chk_reset("reset");
        cycle(32'h0, 0, 1, 5'd1, 32'd5, 0, 1, 0);
        cycle(32'h0, 0, 1, 5'd2, 32'd3, 0, 1, 0);
        cycle(32'h00221820, 1, 0, 0, 0, 0, 1, 0);
        chk("add_valid", 32'(bus.out_valid), 32'h1);
        chk("add_op1", bus.OP1, 32'd5);
        chk("add_op2", bus.OP2, 32'd3);
        chk("add_ctl", 32'(bus.ALUCtl), 32'h2);
        chk("add_wdest", 32'(bus.Wdest), 32'd3);
        chk("add_rw", 32'(bus.RegWrite), 32'h1);
        cycle(32'h2024FFFF, 1, 0, 0, 0, 0, 1, 0);
        chk("addi_op2", bus.OP2, 32'hFFFFFFFF);
        chk("addi_ctl", 32'(bus.ALUCtl), 32'h2);
        cycle(32'h34248000, 1, 0, 0, 0, 0, 1, 0);
        chk("ori_op2", bus.OP2, 32'h00008000);
        chk("ori_ctl", 32'(bus.ALUCtl), 32'h1);
        cycle({6'h00, 5'd6, 5'd7, 5'd5, 5'd0, 6'h22}, 1, 1, 5'd6, 32'h10, 0, 1, 0);
        chk("sub_bypass_op1", bus.OP1, 32'h10);
        chk("sub_ctl", 32'(bus.ALUCtl), 32'h6);
        cycle(32'h00221820, 1, 0, 0, 0, 0, 1, 0);
        cycle(32'h0, 0, 1, 5'd1, 32'h99, 0, 0, 0);
        chk("stall_refresh_op1", bus.OP1, 32'h99);
        chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
        cycle(32'h0, 0, 0, 0, 0, 0, 1, 0);
        chk("consume_valid", 32'(bus.out_valid), 32'h0);
        cycle(32'h34248000, 1, 0, 0, 0, 0, 0, 0);
        cycle(32'h00221820, 1, 0, 0, 0, 1, 0, 0);
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        cycle(32'h0, 0, 0, 0, 0, 0, 1, 0);
        chk("flush_no_ghost", 32'(bus.out_valid), 32'h0);
        cycle({6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h25}, 1, 1, 5'd0, 32'hDEAD, 0, 1, 0);
        chk("r0_op1", bus.OP1, 32'h0);
        chk("r0_op2", bus.OP2, 32'h0);
        cycle(32'hFC000000, 1, 0, 0, 0, 0, 1, 0);
        chk("ill_valid", 32'(bus.out_valid), 32'h1);
        chk("ill_flag", 32'(bus.Illegal), 32'h1);
        chk("ill_ctl", 32'(bus.ALUCtl), 32'h3);
        chk("ill_rw", 32'(bus.RegWrite), 32'h0);
        cycle(32'h00221820, 1, 0, 0, 0, 0, 1, 0);
        cycle(32'h0, 0, 0, 0, 0, 0, 0, 0);
        cycle(32'h0, 0, 1, 5'd2, 32'h7, 1, 0, 1);
        chk_reset("stall_reset");
        cycle(32'h00221820, 1, 0, 0, 0, 0, 1, 0);
        chk("post_reset_r1", bus.OP1, 32'h0);
        chk("post_reset_r2", bus.OP2, 32'h0);
        for (int n = 0; n < 3000; n++)
            cycle(gen_instr(), $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 255) == 0);
        for (int n = 0; n < 4; n++) cycle(32'h0, 0, 0, 0, 0, 0, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
